// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, rx FSM states, oversampling
// constants and a 2-of-3 majority helper, for uart_rx_os and uart_tx_os.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DIV_W_DEF  = 16;

    localparam logic [3:0] VOTE_S0     = 4'd7;
    localparam logic [3:0] VOTE_S1     = 4'd8;
    localparam logic [3:0] VOTE_S2     = 4'd9;
    localparam logic [3:0] LAST_SAMPLE = 4'd15;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        WAIT_IDLE
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversampling tick generator: counts 0..div while enabled, one tick at wrap.
// Ports: Clk, Rst_n, en (run), clr (restart count), div (period-1), tick out.
module uart_os_tick
    import uart_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (cnt == div) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && !clr && (cnt == div);

endmodule

// File: rtl/uart_rx_os.sv
// UART receiver, 16x oversampling with 2-of-3 vote, runtime baud divisor.
// Ports: Clk, Rst_n, baud_div, parity_mode, two_stop, uart_rx in;
// data_out, rx_valid, parity_err, frame_err, break_det, busy out.
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = uart_pkg::DIV_W_DEF
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);
    import uart_pkg::*;

    if (OVERSAMPLE != uart_pkg::OVERSAMPLE || DATA_BITS < 5 || DATA_BITS > 9)
    begin : g_bad_param
        $error("uart_rx_os: unsupported DATA_BITS or OVERSAMPLE");
    end

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    rx_state_e state, state_n;

    logic                 sync1, rxs, rxs_d;
    logic [1:0]           warm;
    logic                 armed;
    logic                 fall;
    logic [DIV_W-1:0]     div_l;
    logic [1:0]           mode_l;
    logic                 two_l;
    logic                 tick;
    logic [3:0]           scnt;
    logic [3:0]           bcnt;
    logic                 v7, v8;
    logic                 vote;
    logic                 decide, bit_end;
    logic [DATA_BITS-1:0] sh;
    logic                 pbit;
    logic                 stop1_v;
    logic                 par_en;
    logic                 finish;
    logic                 stop_ok;
    logic                 first_stop;
    logic                 brk;

    // Edges are armed only once the synchroniser holds a real high
    // sample, so a line that is low at reset release is not a start.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
            warm  <= 2'b00;
            armed <= 1'b0;
        end else begin
            sync1 <= uart_rx;
            rxs   <= sync1;
            rxs_d <= rxs;
            warm  <= {warm[0], 1'b1};
            armed <= armed | (warm[1] & rxs);
        end
    end

    assign fall = armed & rxs_d & ~rxs;
    assign busy = (state != IDLE);

    uart_os_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .en    (busy),
        .clr   (fall && state == IDLE),
        .div   (div_l),
        .tick  (tick)
    );

    assign vote    = maj3(v7, v8, rxs);
    assign decide  = tick && (scnt == VOTE_S2);
    assign bit_end = tick && (scnt == LAST_SAMPLE);
    assign par_en  = (mode_l == PAR_ODD) || (mode_l == PAR_EVEN);

    assign finish = decide &&
        ((state == STOP1 && !two_l) || state == STOP2);
    assign first_stop = (state == STOP2) ? stop1_v : vote;
    assign stop_ok    = vote && first_stop;
    assign brk = ~|sh && !(par_en && pbit) && !first_stop;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (fall) state_n = START;
            end
            START: begin
                if (decide && vote) state_n = IDLE;
                else if (bit_end)   state_n = DATA;
            end
            DATA: begin
                if (bit_end && bcnt == LAST_BIT)
                    state_n = par_en ? PARITY : STOP1;
            end
            PARITY: begin
                if (bit_end) state_n = STOP1;
            end
            STOP1: begin
                if (decide && !two_l)
                    state_n = vote ? IDLE : WAIT_IDLE;
                else if (bit_end && two_l)
                    state_n = STOP2;
            end
            STOP2: begin
                if (decide) state_n = stop_ok ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (tick && rxs && scnt == LAST_SAMPLE) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            div_l      <= '0;
            mode_l     <= PAR_NONE;
            two_l      <= 1'b0;
            scnt       <= '0;
            bcnt       <= '0;
            v7         <= 1'b1;
            v8         <= 1'b1;
            sh         <= '0;
            pbit       <= 1'b0;
            stop1_v    <= 1'b1;
            data_out   <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            if (state == IDLE && fall) begin
                div_l  <= baud_div;
                mode_l <= parity_mode;
                two_l  <= two_stop;
                scnt   <= '0;
                bcnt   <= '0;
            end else if (finish) begin
                scnt <= '0;
            end else if (state == WAIT_IDLE && !rxs) begin
                // Restart the 16-tick idle qualification on any low.
                scnt <= '0;
            end else if (tick) begin
                scnt <= scnt + 1'b1;
            end

            if (tick && scnt == VOTE_S0) v7 <= rxs;
            if (tick && scnt == VOTE_S1) v8 <= rxs;

            if (decide && state == DATA)   sh      <= {vote, sh[DATA_BITS-1:1]};
            if (decide && state == PARITY) pbit    <= vote;
            if (decide && state == STOP1)  stop1_v <= vote;

            if (bit_end && state == DATA) bcnt <= bcnt + 1'b1;

            if (finish) begin
                rx_valid   <= 1'b1;
                data_out   <= sh;
                parity_err <= par_en &&
                    ((mode_l == PAR_ODD) ? ~^{sh, pbit} : ^{sh, pbit});
                frame_err  <= !stop_ok;
                break_det  <= !stop_ok && brk;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: frames are built from the line protocol,
// expected results queued at send time and checked on every rx_valid.
module tb_uart_rx_os;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [15:0] baud_div = 16'd26;
    logic [1:0]  parity_mode = 2'd0;
    logic        two_stop = 1'b0;
    logic        uart_rx = 1'b1;
    logic [7:0]  data_out;
    logic        rx_valid;
    logic        parity_err;
    logic        frame_err;
    logic        break_det;
    logic        busy;

    uart_rx_os #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .DIV_W      (16)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .uart_rx     (uart_rx),
        .data_out    (data_out),
        .rx_valid    (rx_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .break_det   (break_det),
        .busy        (busy)
    );

    always #10 Clk = ~Clk;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge Clk) begin
        if (Rst_n && rx_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rx_valid: got data %0h, expected no frame",
                         data_out);
            end else begin
                mon_e = sb.pop_front();
                chk("data_out",   32'(data_out),   32'(mon_e.d));
                chk("parity_err", 32'(parity_err), 32'(mon_e.pe));
                chk("frame_err",  32'(frame_err),  32'(mon_e.fe));
                chk("break_det",  32'(break_det),  32'(mon_e.bk));
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic drive_bit(input logic v, input int div);
        uart_rx = v;
        wait_clks(16 * (div + 1));
    endtask

    task automatic idle_ticks(input int n, input int div);
        uart_rx = 1'b1;
        wait_clks(n * (div + 1));
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] mode,
                              input logic two, input int div,
                              input logic par_wrong, input logic s1,
                              input logic s2, input logic scramble);
        logic pen;
        logic p;
        exp_t e;
        pen  = (mode == 2'd1) || (mode == 2'd2);
        p    = ((mode == 2'd1) ? ~^d : ^d) ^ par_wrong;
        e.d  = d;
        e.pe = pen && par_wrong;
        e.fe = !s1 || (two && !s2);
        e.bk = e.fe && (d == 8'h00) && !(pen && p) && !s1;
        sb.push_back(e);
        baud_div    = 16'(div);
        parity_mode = mode;
        two_stop    = two;
        uart_rx     = 1'b0;
        wait_clks(8);
        if (scramble) begin
            baud_div    = 16'($urandom_range(0, 40));
            parity_mode = 2'($urandom_range(0, 3));
            two_stop    = 1'($urandom_range(0, 1));
        end
        wait_clks(16 * (div + 1) - 8);
        for (int i = 0; i < 8; i++) drive_bit(d[i], div);
        if (pen) drive_bit(p, div);
        drive_bit(s1, div);
        if (two) drive_bit(s2, div);
    endtask

    initial begin
        wait_clks(2_000_00);
        $display("FAIL timeout: simulation did not finish within cycle budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic [1:0] m;
        logic       two, pw, s1, s2;
        int         div;

        wait_clks(3);
        chk("reset_data_out",   32'(data_out),   0);
        chk("reset_rx_valid",   32'(rx_valid),   0);
        chk("reset_parity_err", 32'(parity_err), 0);
        chk("reset_frame_err",  32'(frame_err),  0);
        chk("reset_break_det",  32'(break_det),  0);
        chk("reset_busy",       32'(busy),       0);
        Rst_n = 1'b1;
        idle_ticks(20, 3);

        // 8N1 at 115200 from 50 MHz
        send_frame(8'h55, 2'd0, 1'b0, 26, 1'b0, 1'b1, 1'b1, 1'b0);
        idle_ticks(16, 26);

        // 8E1 with the parity bit inverted
        send_frame(8'hA3, 2'd2, 1'b0, 3, 1'b1, 1'b1, 1'b1, 1'b0);
        idle_ticks(16, 3);

        // 5-tick low glitch is a false start
        uart_rx = 1'b0;
        wait_clks(5 * 4);
        chk("glitch_busy_high", 32'(busy), 1);
        uart_rx = 1'b1;
        wait_clks(8 * 4);
        chk("glitch_busy_low", 32'(busy), 0);
        idle_ticks(16, 3);

        // framing error, recover, then a clean frame
        send_frame(8'h3C, 2'd0, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_ticks(20, 3);
        chk("ferr_recover_busy", 32'(busy), 0);
        send_frame(8'h81, 2'd0, 1'b0, 3, 1'b0, 1'b1, 1'b1, 1'b0);
        idle_ticks(16, 3);

        // break: line low for two frame times
        send_frame(8'h00, 2'd0, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0);
        uart_rx = 1'b0;
        wait_clks(10 * 16 * 4);
        chk("break_wait_busy", 32'(busy), 1);
        idle_ticks(20, 3);
        chk("break_idle_busy", 32'(busy), 0);

        // randomized frames, config scrambled mid-frame
        for (int n = 0; n < 14; n++) begin
            d   = 8'($urandom);
            if ($urandom_range(0, 5) == 0) d = 8'h00;
            m   = 2'($urandom_range(0, 3));
            two = 1'($urandom_range(0, 1));
            div = $urandom_range(0, 5);
            pw  = ($urandom_range(0, 3) == 0);
            s1  = ($urandom_range(0, 4) != 0);
            s2  = ($urandom_range(0, 4) != 0);
            send_frame(d, m, two, div, pw, s1, s2, 1'b1);
            if (!s1 || (two && !s2)) idle_ticks(20, div);
            else idle_ticks(16 * $urandom_range(0, 2), div);
        end
        idle_ticks(20, 5);

        // back-to-back 8N2, then reset in the middle of a third frame
        send_frame(8'h12, 2'd0, 1'b1, 2, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h34, 2'd0, 1'b1, 2, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b0, 2);
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 2);
        drive_bit(1'b1, 2);
        uart_rx = 1'b0;
        wait_clks(8 * 3);
        Rst_n = 1'b0;
        wait_clks(3);
        chk("midreset_busy",     32'(busy),     0);
        chk("midreset_data_out", 32'(data_out), 0);
        chk("midreset_rx_valid", 32'(rx_valid), 0);
        uart_rx = 1'b1;
        Rst_n = 1'b1;
        idle_ticks(16 * 14, 2);
        chk("post_reset_busy", 32'(busy), 0);

        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
